// File: rtl/tpu_run_sequencer.sv
// rtl/tpu_run_sequencer.sv - run controller for the systolic TPU datapath
// Turns a start pulse into weight load, UB stream, drain, result write-back and a done pulse.

module tpu_run_sequencer #(
  parameter int ADDRESSSIZE  = 10,
  parameter int FIFO_ADDR_BW = 2,
  parameter int MATRIX_SIZE  = 16,
  parameter int WLOAD_CYCLES = 2,
  parameter int DRAIN_CYCLES = 31
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDRESSSIZE-1:0]  ub_base,
  input  logic [ADDRESSSIZE-1:0]  res_base,
  input  logic [FIFO_ADDR_BW-1:0] weight_sel,
  output logic                    busy,
  output logic                    done,
  output logic                    we_rl,
  output logic [FIFO_ADDR_BW-1:0] fifo_addr,
  output logic                    ub_rd_en,
  output logic [ADDRESSSIZE-1:0]  ub_rd_addr,
  output logic                    res_wr_en,
  output logic [ADDRESSSIZE-1:0]  res_wr_addr
);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, WB, DONE} state_t;

  localparam int MAX_A   = (WLOAD_CYCLES > MATRIX_SIZE) ? WLOAD_CYCLES : MATRIX_SIZE;
  localparam int MAX_LEN = (MAX_A > DRAIN_CYCLES) ? MAX_A : DRAIN_CYCLES;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] WL_LAST = CNT_W'(WLOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MS_LAST = CNT_W'(MATRIX_SIZE - 1);
  localparam logic [CNT_W-1:0] DR_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [CNT_W-1:0]        k;
  logic [ADDRESSSIZE-1:0]  ub_base_q, res_base_q;
  logic [FIFO_ADDR_BW-1:0] wsel_q;
  logic                    accept;

  logic                    busy_n, done_n, we_rl_n, ub_rd_en_n, res_wr_en_n;
  logic [FIFO_ADDR_BW-1:0] fifo_addr_n;
  logic [ADDRESSSIZE-1:0]  ub_rd_addr_n, res_wr_addr_n;

  assign accept = (state == IDLE) && start && !abort;
  // Down-counter runs MS_LAST..0 in STREAM/WB, so the row index counts up.
  assign k = MS_LAST - cnt;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (abort && state != IDLE) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          state_next = LOAD_W;
          cnt_next   = WL_LAST;
        end
        LOAD_W: if (cnt == '0) begin
          state_next = STREAM;
          cnt_next   = MS_LAST;
        end else cnt_next = cnt - 1'b1;
        STREAM: if (cnt == '0) begin
          state_next = DRAIN;
          cnt_next   = DR_LAST;
        end else cnt_next = cnt - 1'b1;
        DRAIN: if (cnt == '0) begin
          state_next = WB;
          cnt_next   = MS_LAST;
        end else cnt_next = cnt - 1'b1;
        WB: if (cnt == '0) begin
          state_next = DONE;
          cnt_next   = '0;
        end else cnt_next = cnt - 1'b1;
        DONE: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Output registers follow the current phase; abort zeroes flags and freezes addresses.
  always_comb begin
    busy_n        = 1'b0;
    done_n        = 1'b0;
    we_rl_n       = 1'b0;
    ub_rd_en_n    = 1'b0;
    res_wr_en_n   = 1'b0;
    fifo_addr_n   = fifo_addr;
    ub_rd_addr_n  = ub_rd_addr;
    res_wr_addr_n = res_wr_addr;
    if (!abort && state != IDLE) begin
      busy_n      = 1'b1;
      fifo_addr_n = wsel_q;
      done_n      = (state == DONE);
      we_rl_n     = (state == LOAD_W);
      if (state == STREAM) begin
        ub_rd_en_n   = 1'b1;
        ub_rd_addr_n = ub_base_q + ADDRESSSIZE'(k);
      end
      if (state == WB) begin
        res_wr_en_n   = 1'b1;
        res_wr_addr_n = res_base_q + ADDRESSSIZE'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      ub_base_q   <= '0;
      res_base_q  <= '0;
      wsel_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      we_rl       <= 1'b0;
      fifo_addr   <= '0;
      ub_rd_en    <= 1'b0;
      ub_rd_addr  <= '0;
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      if (accept) begin
        ub_base_q  <= ub_base;
        res_base_q <= res_base;
        wsel_q     <= weight_sel;
      end
      busy        <= busy_n;
      done        <= done_n;
      we_rl       <= we_rl_n;
      fifo_addr   <= fifo_addr_n;
      ub_rd_en    <= ub_rd_en_n;
      ub_rd_addr  <= ub_rd_addr_n;
      res_wr_en   <= res_wr_en_n;
      res_wr_addr <= res_wr_addr_n;
    end
  end

endmodule

// File: tb/tb_tpu_run_sequencer.sv
// tb/tb_tpu_run_sequencer.sv - self-checking bench for tpu_run_sequencer
// Timeline model: every output is derived from the offset since the accepted start edge.

module tb_tpu_run_sequencer;

  localparam int W = 2;
  localparam int M = 16;
  localparam int D = 31;
  localparam int L = 1 + W + M + D + M;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [9:0] ub_base = '0;
  logic [9:0] res_base = '0;
  logic [1:0] weight_sel = '0;
  logic       busy, done, we_rl, ub_rd_en, res_wr_en;
  logic [1:0] fifo_addr;
  logic [9:0] ub_rd_addr, res_wr_addr;

  tpu_run_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .ub_base(ub_base), .res_base(res_base), .weight_sel(weight_sel),
    .busy(busy), .done(done), .we_rl(we_rl), .fifo_addr(fifo_addr),
    .ub_rd_en(ub_rd_en), .ub_rd_addr(ub_rd_addr),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state
  int         cyc, t0, d;
  bit         act;
  logic [9:0] mu, mr;
  logic [1:0] mw;
  logic       m_busy, m_done, m_we, m_ub_en, m_res_en;
  logic [1:0] m_fifo;
  logic [9:0] m_ub_addr, m_res_addr;

  initial forever begin
    @(posedge clk or posedge rstn);
    if (rstn) begin
      act = 0; cyc = 0; t0 = 0; mu = '0; mr = '0; mw = '0;
      m_busy = 0; m_done = 0; m_we = 0; m_ub_en = 0; m_res_en = 0;
      m_fifo = '0; m_ub_addr = '0; m_res_addr = '0;
    end else begin
      cyc++;
      if (act && (cyc - t0) <= L && abort) begin
        act = 0;
        m_busy = 0; m_done = 0; m_we = 0; m_ub_en = 0; m_res_en = 0;
      end else begin
        if ((!act || (cyc - t0) > L) && start && !abort) begin
          act = 1; t0 = cyc; mu = ub_base; mr = res_base; mw = weight_sel;
        end
        d = act ? (cyc - t0) : L + 100;
        m_busy   = (d >= 1) && (d <= L);
        m_done   = (d == L);
        m_we     = (d >= 1) && (d <= W);
        m_ub_en  = (d >= W + 1) && (d <= W + M);
        m_res_en = (d >= W + M + D + 1) && (d <= W + M + D + M);
        if (m_busy)   m_fifo     = mw;
        if (m_ub_en)  m_ub_addr  = mu + 10'(d - W - 1);
        if (m_res_en) m_res_addr = mr + 10'(d - (W + M + D + 1));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("we_rl", we_rl, m_we);
      chk("fifo_addr", fifo_addr, m_fifo);
      chk("ub_rd_en", ub_rd_en, m_ub_en);
      chk("ub_rd_addr", ub_rd_addr, m_ub_addr);
      chk("res_wr_en", res_wr_en, m_res_en);
      chk("res_wr_addr", res_wr_addr, m_res_addr);
      chk("no_overlap", ub_rd_en & res_wr_en, 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(input logic [9:0] ub, input logic [9:0] rb, input logic [1:0] ws);
    ub_base = ub; res_base = rb; weight_sel = ws; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;

  initial begin
    step(3);
    rstn = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_busy", busy, 0);
    end

    // Basic run
    go(10'h010, 10'h200, 2'd2);
    chk("basic_d0_busy", busy, 0);
    step(1);
    chk("basic_we_first", we_rl, 1);
    chk("basic_fifo", fifo_addr, 2);
    step(2);
    chk("basic_ub_first", ub_rd_addr, 10'h010);
    step(15);
    chk("basic_ub_last", ub_rd_addr, 10'h01F);
    step(1);
    chk("basic_drain_en", ub_rd_en, 0);
    step(31);
    chk("basic_res_first", res_wr_addr, 10'h200);
    step(15);
    chk("basic_res_last", res_wr_addr, 10'h20F);
    step(1);
    chk("basic_done", done, 1);
    step(1);
    chk("basic_after_done", done, 0);
    chk("basic_after_busy", busy, 0);
    step(3);

    // Address wrap
    go(10'h3F8, 10'h3FC, 2'd3);
    step(11);
    chk("wrap_ub_zero", ub_rd_addr, 10'h000);
    step(7);
    chk("wrap_ub_last", ub_rd_addr, 10'h007);
    step(36);
    chk("wrap_res_zero", res_wr_addr, 10'h000);
    step(11);
    chk("wrap_res_last", res_wr_addr, 10'h00B);
    step(1);
    chk("wrap_done", done, 1);
    step(3);

    // Start while busy is ignored
    done_cnt = 0;
    go(10'h100, 10'h180, 2'd1);
    step(30);
    ub_base = 10'h2AA; res_base = 10'h055; weight_sel = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    step(19);
    chk("busy_start_res", res_wr_addr, 10'h180);
    step(40);
    chk("busy_start_dones", done_cnt, 1);
    chk("busy_start_fifo", fifo_addr, 1);

    // Abort during STREAM at k=5
    done_cnt = 0;
    go(10'h050, 10'h060, 2'd0);
    step(8);
    chk("abort_pre_addr", ub_rd_addr, 10'h055);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ub_en", ub_rd_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr_hold", ub_rd_addr, 10'h055);
    go(10'h070, 10'h080, 2'd1);
    wait_done(lat);
    chk("abort_restart_lat", lat, L);
    chk("abort_dones", done_cnt, 1);
    step(3);

    // Start together with abort in IDLE
    ub_base = 10'h001; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    step(2);
    chk("start_abort_busy2", busy, 0);

    // Back-to-back runs with start held
    ub_base = 10'h0A0; res_base = 10'h0B0; weight_sel = 2'd2; start = 1'b1;
    @(negedge clk);
    wait_done(lat);
    chk("b2b_first_lat", lat, L);
    step(1);
    wait_done(lat);
    chk("b2b_spacing", lat + 1, L + 1);
    start = 1'b0;
    step(5);
    chk("b2b_idle", busy, 0);

    // Asynchronous reset mid-run
    done_cnt = 0;
    go(10'h123, 10'h321, 2'd3);
    step(20);
    #2 rstn = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ub_en", ub_rd_en, 0);
    chk("arst_ub_addr", ub_rd_addr, 0);
    chk("arst_fifo", fifo_addr, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rstn = 1'b0;
    step(80);
    chk("arst_no_done", done_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
